// File: rtl/nmea_frame_ctrl.sv
// NMEA-0183 sentence framer: matches "$<HDR>,", streams body fields, checks the
// "*hh" XOR checksum and reports aborts (checksum, overflow, timeout, format).
module nmea_frame_ctrl #(
    parameter logic [39:0] HDR         = "GNRMC",
    parameter int          MAX_LEN     = 96,
    parameter int          TIMEOUT_CYC = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] po_data,
    input  logic       po_flag,
    output logic       busy,
    output logic       hdr_ok,
    output logic [4:0] field_idx,
    output logic [7:0] field_char,
    output logic       field_stb,
    output logic       field_end,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam int              GW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GW-1:0]   GAP_MAX  = GW'(TIMEOUT_CYC);
    localparam logic [6:0]      LEN_MAX  = 7'(MAX_LEN);

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_BODY, ST_CK1, ST_CK2, ST_CHK} state_t;

    state_t        state_q;
    logic [7:0]    xor_q;
    logic [2:0]    hdr_cnt_q;
    logic [4:0]    fidx_q;
    logic [6:0]    len_q;
    logic [GW-1:0] gap_q;
    logic [3:0]    ck_hi_q, ck_lo_q;
    logic          hdr_ok_q, field_stb_q, field_end_q, frame_ok_q, frame_err_q;
    logic [4:0]    field_idx_q;
    logic [7:0]    field_char_q;
    logic [1:0]    err_code_q;

    logic [7:0]    hdr_char_d;
    logic          hex_ok_d;
    logic [3:0]    hex_val_d;
    logic [GW-1:0] gap_d;

    always_comb begin
        case (hdr_cnt_q)
            3'd0:    hdr_char_d = HDR[39:32];
            3'd1:    hdr_char_d = HDR[31:24];
            3'd2:    hdr_char_d = HDR[23:16];
            3'd3:    hdr_char_d = HDR[15:8];
            3'd4:    hdr_char_d = HDR[7:0];
            default: hdr_char_d = 8'h2C;
        endcase
    end

    // Uppercase hex only; lowercase digits abort the frame as a format error.
    always_comb begin
        hex_ok_d  = 1'b0;
        hex_val_d = 4'd0;
        if (po_data >= 8'h30 && po_data <= 8'h39) begin
            hex_ok_d  = 1'b1;
            hex_val_d = po_data[3:0];
        end else if (po_data >= 8'h41 && po_data <= 8'h46) begin
            hex_ok_d  = 1'b1;
            hex_val_d = po_data[3:0] + 4'd9;
        end
    end

    assign gap_d = gap_q + GW'(1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            xor_q        <= 8'd0;
            hdr_cnt_q    <= 3'd0;
            fidx_q       <= 5'd0;
            len_q        <= 7'd0;
            gap_q        <= '0;
            ck_hi_q      <= 4'd0;
            ck_lo_q      <= 4'd0;
            hdr_ok_q     <= 1'b0;
            field_stb_q  <= 1'b0;
            field_end_q  <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            field_idx_q  <= 5'd0;
            field_char_q <= 8'd0;
            err_code_q   <= 2'd0;
        end else begin
            hdr_ok_q    <= 1'b0;
            field_stb_q <= 1'b0;
            field_end_q <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            gap_q       <= (po_flag || state_q == ST_IDLE) ? '0 : gap_d;

            if (state_q == ST_CHK) begin
                if (xor_q == {ck_hi_q, ck_lo_q}) begin
                    frame_ok_q <= 1'b1;
                end else begin
                    frame_err_q <= 1'b1;
                    err_code_q  <= 2'd0;
                end
                state_q <= ST_IDLE;
            end else if (po_flag) begin
                if (po_data == "$") begin
                    // A '$' always starts a fresh header; mid-frame it also aborts the old one.
                    if (state_q != ST_IDLE) begin
                        frame_err_q <= 1'b1;
                        err_code_q  <= 2'd3;
                    end
                    state_q     <= ST_HDR;
                    xor_q       <= 8'd0;
                    hdr_cnt_q   <= 3'd0;
                    fidx_q      <= 5'd0;
                    len_q       <= 7'd0;
                    field_idx_q <= 5'd0;
                end else begin
                    case (state_q)
                        ST_HDR: begin
                            xor_q <= xor_q ^ po_data;
                            if (po_data != hdr_char_d) begin
                                state_q <= ST_IDLE;
                            end else if (hdr_cnt_q == 3'd5) begin
                                hdr_ok_q <= 1'b1;
                                state_q  <= ST_BODY;
                            end else begin
                                hdr_cnt_q <= hdr_cnt_q + 3'd1;
                            end
                        end
                        ST_BODY: begin
                            if (po_data == "*") begin
                                field_end_q <= 1'b1;
                                field_idx_q <= fidx_q;
                                state_q     <= ST_CK1;
                            end else if (len_q == LEN_MAX) begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'd1;
                                state_q     <= ST_IDLE;
                            end else begin
                                xor_q       <= xor_q ^ po_data;
                                len_q       <= len_q + 7'd1;
                                field_idx_q <= fidx_q;
                                if (po_data == ",") begin
                                    field_end_q <= 1'b1;
                                    if (fidx_q != 5'd31) fidx_q <= fidx_q + 5'd1;
                                end else begin
                                    field_stb_q  <= 1'b1;
                                    field_char_q <= po_data;
                                end
                            end
                        end
                        ST_CK1, ST_CK2: begin
                            if (!hex_ok_d) begin
                                frame_err_q <= 1'b1;
                                err_code_q  <= 2'd3;
                                state_q     <= ST_IDLE;
                            end else if (state_q == ST_CK1) begin
                                ck_hi_q <= hex_val_d;
                                state_q <= ST_CK2;
                            end else begin
                                ck_lo_q <= hex_val_d;
                                state_q <= ST_CHK;
                            end
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end else if (state_q != ST_IDLE && gap_d == GAP_MAX) begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd2;
                state_q     <= ST_IDLE;
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign hdr_ok     = hdr_ok_q;
    assign field_idx  = field_idx_q;
    assign field_char = field_char_q;
    assign field_stb  = field_stb_q;
    assign field_end  = field_end_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
endmodule

// File: tb/tb_nmea_frame_ctrl.sv
// Bench for nmea_frame_ctrl: directed sentences plus random traffic, checked as an
// ordered event stream against a string-level sentence model.
module tb_nmea_frame_ctrl;
    localparam int MAXL = 96;
    localparam int TO   = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'd0;
    logic       flag = 1'b0;
    logic       busy, hdr_ok, field_stb, field_end, frame_ok, frame_err;
    logic [4:0] field_idx;
    logic [7:0] field_char;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    nmea_frame_ctrl #(.HDR("GNRMC"), .MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .po_data(data), .po_flag(flag),
        .busy(busy), .hdr_ok(hdr_ok), .field_idx(field_idx), .field_char(field_char),
        .field_stb(field_stb), .field_end(field_end), .frame_ok(frame_ok),
        .frame_err(frame_err), .err_code(err_code)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    bit mon_en = 1'b0;
    int pulse_n;
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic [7:0]  pkt[$];

    // Event word: {kind, field index, char, err code}. kinds: 1 hdr, 2 stb, 3 end, 4 ok, 5 err.
    function automatic logic [17:0] ev(input logic [2:0] t, input logic [4:0] idx,
                                       input logic [7:0] ch, input logic [1:0] code);
        return {t, idx, ch, code};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vec_cnt++;
        assert (o === e) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            pulse_n = int'(hdr_ok) + int'(field_stb) + int'(field_end) + int'(frame_ok) + int'(frame_err);
            vec_cnt++;
            assert (pulse_n <= 1) else begin
                err_cnt++;
                $error("FAIL pulse_excl observed=%0d expected<=1", pulse_n);
            end
            if (hdr_ok)    obs_q.push_back(ev(3'd1, 5'd0, 8'd0, 2'd0));
            if (field_stb) obs_q.push_back(ev(3'd2, field_idx, field_char, 2'd0));
            if (field_end) obs_q.push_back(ev(3'd3, field_idx, 8'd0, 2'd0));
            if (frame_ok)  obs_q.push_back(ev(3'd4, 5'd0, 8'd0, 2'd0));
            if (frame_err) obs_q.push_back(ev(3'd5, 5'd0, 8'd0, err_code));
        end
    end

    // ---------------- reference model: works on the text of the current sentence
    string      hdr_s = "GNRMC,";
    bit         m_active = 1'b0;
    logic [7:0] m_buf[$];

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
    endfunction

    function automatic logic [3:0] hex_v(input logic [7:0] c);
        if (c <= "9") return 4'(c - "0");
        return 4'(c - "A" + 10);
    endfunction

    function automatic logic [7:0] hex_c(input logic [3:0] v);
        if (v < 10) return 8'("0" + v);
        return 8'("A" + v - 10);
    endfunction

    function automatic void model_feed(input logic [7:0] b);
        int n, star, commas;
        logic [7:0] x;
        if (b == "$") begin
            if (m_active) exp_q.push_back(ev(3'd5, 5'd0, 8'd0, 2'd3));
            m_buf.delete();
            m_active = 1'b1;
            return;
        end
        if (!m_active) return;
        n = m_buf.size();
        m_buf.push_back(b);
        if (n < 6) begin
            if (b != hdr_s[n]) m_active = 1'b0;
            else if (n == 5) exp_q.push_back(ev(3'd1, 5'd0, 8'd0, 2'd0));
            return;
        end
        star = -1;
        for (int i = 6; i < n; i++) if (m_buf[i] == "*") begin star = i; break; end
        if (star < 0) begin
            commas = 0;
            for (int i = 6; i < n; i++) if (m_buf[i] == ",") commas++;
            if (commas > 31) commas = 31;
            if (b == "*") begin
                exp_q.push_back(ev(3'd3, 5'(commas), 8'd0, 2'd0));
            end else if (n - 5 > MAXL) begin
                exp_q.push_back(ev(3'd5, 5'd0, 8'd0, 2'd1));
                m_active = 1'b0;
            end else if (b == ",") begin
                exp_q.push_back(ev(3'd3, 5'(commas), 8'd0, 2'd0));
            end else begin
                exp_q.push_back(ev(3'd2, 5'(commas), b, 2'd0));
            end
        end else if (!is_hex(b)) begin
            exp_q.push_back(ev(3'd5, 5'd0, 8'd0, 2'd3));
            m_active = 1'b0;
        end else if (n - star == 2) begin
            x = 8'd0;
            for (int i = 0; i < star; i++) x = x ^ m_buf[i];
            if (x == {hex_v(m_buf[star + 1]), hex_v(b)}) exp_q.push_back(ev(3'd4, 5'd0, 8'd0, 2'd0));
            else exp_q.push_back(ev(3'd5, 5'd0, 8'd0, 2'd0));
            m_active = 1'b0;
        end
    endfunction

    function automatic void model_timeout();
        if (m_active) exp_q.push_back(ev(3'd5, 5'd0, 8'd0, 2'd2));
        m_active = 1'b0;
    endfunction

    // ---------------- drivers
    task automatic send_byte(input logic [7:0] b, input int gap);
        model_feed(b);
        data = b;
        flag = 1'b1;
        @(posedge clk); #1;
        flag = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) pkt.push_back(s[i]);
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], $urandom_range(3, 1));
        pkt.delete();
    endtask

    task automatic send_str(input string s);
        push_str(s);
        send_pkt();
    endtask

    task automatic add_cs(input bit bad);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 1; i < pkt.size(); i++) x = x ^ pkt[i];
        if (bad) x = x ^ 8'($urandom_range(255, 1));
        pkt.push_back("*");
        pkt.push_back(hex_c(x[7:4]));
        pkt.push_back(hex_c(x[3:0]));
    endtask

    task automatic check_events(input string tag);
        repeat (4) begin @(posedge clk); #1; end
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_event"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
    endtask

    string alpha = "0123456789ABCZ.-,";
    string junk  = "$GNRMC,*0A1Fg";
    int    kind, blen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hdr_ok", hdr_ok, 0);
        check("rst_field_idx", field_idx, 0);
        check("rst_field_char", field_char, 0);
        check("rst_field_stb", field_stb, 0);
        check("rst_field_end", field_end, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // good sentence, with checksum-result latency
        send_str("$GNRMC,1,A*2");
        send_byte("5", 0);
        check("ok_lat1", frame_ok, 0);
        @(posedge clk); #1;
        check("ok_lat2", frame_ok, 1);
        check_events("good");

        send_str("$GNRMC,1,A*26");
        check_events("bad_cs");
        check("bad_cs_code", err_code, 0);

        // foreign header dropped silently after the mismatching byte
        send_byte("$", 1);
        send_byte("G", 0);
        check("gpgga_busy_g", busy, 1);
        send_byte("P", 0);
        check("gpgga_busy_p", busy, 0);
        send_str("GA,1,2*00");
        check_events("gpgga");

        // inter-byte timeout
        send_str("$GNRMC,1");
        send_byte("2", 0);
        repeat (99) @(posedge clk);
        #1;
        check("to_early", frame_err, 0);
        @(posedge clk); #1;
        check("to_err", frame_err, 1);
        check("to_code", err_code, 2);
        check("to_busy", busy, 0);
        model_timeout();
        check_events("timeout");
        check("to_code_held", err_code, 2);

        send_str("$GNRMC,1$GNRMC,1,A*25");
        check_events("restart");

        push_str("$GNRMC,");
        for (int i = 0; i < 97; i++) pkt.push_back("X");
        send_pkt();
        check_events("overflow");
        check("ovf_code", err_code, 1);

        push_str("$GNRMC,");
        for (int i = 0; i < 96; i++) pkt.push_back("X");
        add_cs(1'b0);
        send_pkt();
        check_events("len_max");

        send_str("$GNRMC,1,A*2G");
        check_events("bad_hex");
        check("bad_hex_code", err_code, 3);

        push_str("$GNRMC,");
        for (int i = 0; i < 40; i++) pkt.push_back(",");
        pkt.push_back("Z");
        add_cs(1'b0);
        send_pkt();
        check_events("idx_sat");

        // reset mid-frame abandons it silently
        send_str("$GNRMC,1");
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_busy", busy, 0);
        check("mrst_err", frame_err, 0);
        check("mrst_code", err_code, 0);
        rst_n = 1'b1;
        m_active = 1'b0;
        m_buf.delete();
        send_str("GNRMC,1,A*25");
        check_events("mid_reset");

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(4, 0);
            case (kind)
                0, 1: begin
                    push_str("$GNRMC,");
                    blen = $urandom_range(20, 0);
                    for (int i = 0; i < blen; i++) pkt.push_back(alpha[$urandom_range(alpha.len() - 1, 0)]);
                    add_cs(kind == 1);
                end
                2: begin
                    blen = $urandom_range(15, 1);
                    for (int i = 0; i < blen; i++) pkt.push_back(junk[$urandom_range(junk.len() - 1, 0)]);
                end
                3: begin
                    push_str("$GNRMC,");
                    pkt[$urandom_range(6, 1)] = "Q";
                    push_str("1,2");
                    add_cs(1'b0);
                end
                default: begin
                    push_str("$GNRMC,");
                    blen = $urandom_range(100, 90);
                    for (int i = 0; i < blen; i++) pkt.push_back("X");
                    add_cs(1'b0);
                end
            endcase
            send_pkt();
            check_events("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/nmea_frame_ctrl.md
NMEA_FRAME_CTRL -- requirements
Module: nmea_frame_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- HDR, "GNRMC", 5-character sentence identifier accepted after '$'.
- MAX_LEN, 96, maximum body bytes (after header comma, before '*').
- TIMEOUT_CYC, 50_000_000, maximum sys_clk cycles between accepted bytes while in a frame.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- sys_clk, in, 1, sole clock; all logic on posedge.
- sys_rst_n, in, 1, synchronous active-low reset.
- po_data, in, 8, received UART byte.
- po_flag, in, 1, one-cycle strobe qualifying po_data.
- busy, out, 1, high in any state other than IDLE.
- hdr_ok, out, 1, one-cycle pulse when header plus comma match.
- field_idx, out, 5, current comma-separated field number; 0 is the first field after the header.
- field_char, out, 8, body character (registered copy of po_data).
- field_stb, out, 1, one-cycle pulse; field_char is valid.
- field_end, out, 1, one-cycle pulse on a ',' or '*' that terminates field field_idx.
- frame_ok, out, 1, one-cycle pulse when the checksum matches.
- frame_err, out, 1, one-cycle pulse when a frame is aborted.
- err_code, out, 2, reason for the abort; valid with frame_err and held until the next frame_err.

Function
REQ-003 The state machine SHALL use these states: IDLE, HDR, BODY, CK1, CK2, CHK.
REQ-004 Bytes SHALL be consumed only when po_flag=1; outputs SHALL be registered and appear 1 cycle after the po_flag cycle.
REQ-005 IDLE: on '$' (0x24), go to HDR; clear xor_acc, hdr_cnt, field_idx, len_cnt. All other bytes are ignored.
REQ-006 HDR: each byte SHALL be XORed into xor_acc and compared to HDR char hdr_cnt.
- The 6th byte must be ','; a match pulses hdr_ok and goes to BODY.
- Any mismatch returns to IDLE silently (no frame_err).
REQ-007 BODY, non-'*' bytes: XOR into xor_acc and increment len_cnt.
- ',' pulses field_end and increments field_idx, saturating at 31.
- Any other byte pulses field_stb with field_char.
REQ-008 BODY, '*': do not XOR; pulse field_end; go to CK1.
REQ-009 '$' received in HDR/BODY/CK1/CK2 SHALL raise frame_err with err_code=3 (format) and restart HDR in the same transition, with counters cleared.
REQ-010 In BODY, when len_cnt would exceed MAX_LEN: frame_err, err_code=1 (overflow), go to IDLE.
REQ-011 CK1/CK2 SHALL accept ASCII '0'-'9' and 'A'-'F' into ck_hi/ck_lo (4 bits each).
- Any other byte: frame_err, err_code=3, go to IDLE.
REQ-012 CK2 SHALL go to CHK.
- In CHK (1 cycle, no byte consumed), xor_acc=={ck_hi,ck_lo} pulses frame_ok.
- Otherwise CHK pulses frame_err with err_code=0 (checksum).
- Both outcomes go to IDLE.
- Latency: frame_ok/frame_err = 2 cycles after the 2nd checksum byte's po_flag.
REQ-013 Gap counter:
- Clears on every po_flag and in IDLE.
- Increments otherwise.
- Reaching TIMEOUT_CYC in any non-IDLE state: frame_err, err_code=2 (timeout), go to IDLE.
- Timeout and po_flag in the same cycle: the byte wins and the counter clears.
REQ-014 frame_ok and frame_err SHALL never assert in the same cycle; at most one of hdr_ok/field_stb/field_end/frame_ok/frame_err SHALL assert per cycle.
REQ-015 xor_acc SHALL be 8 bits, with wrap-free XOR.
- len_cnt SHALL be 7 bits.
- The gap counter SHALL be $clog2(TIMEOUT_CYC+1) bits.

Reset
REQ-016 With sys_rst_n=0 at a sys_clk edge:
- State goes to IDLE.
- All outputs go to 0, err_code=0.
- xor_acc, ck_hi, ck_lo, and all counters are cleared.
REQ-017 Reset asserted mid-frame SHALL abandon the frame with no frame_err pulse.
- The first byte after release is treated as in IDLE.

Verification
REQ-018 Send "$GNRMC,1,A*25" -> hdr_ok once; field_stb for '1' (idx 0) and 'A' (idx 1); field_end×2; frame_ok pulse; no frame_err.
REQ-019 Send "$GNRMC,1,A*26" -> frame_err, err_code=0, no frame_ok.
REQ-020 Send "$GPGGA,..." -> no hdr_ok, no field_stb, no frame_err; busy falls after 'P'.
REQ-021 Send "$GNRMC,12" then idle TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in sim) -> frame_err, err_code=2 exactly 100 cycles after the last po_flag; busy=0.
REQ-022 Send "$GNRMC,1$GNRMC,1,A*25" -> frame_err with err_code=3 at the 2nd '$', then frame_ok for the second frame.
REQ-023 Send "$GNRMC," plus 97 'X' bytes (MAX_LEN=96) -> frame_err, err_code=1, on the 97th byte; also send "*2G" after a valid body -> err_code=3.
